// File: rtl/pipeline_cpu_pkg.sv
// Shared encodings, pipeline-register layouts and instruction decode for pipeline_cpu.
package pipeline_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI, ALU_LINK} alu_op_e;
  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    logic    alu_imm;
    logic    use_rs;
    logic    use_rt;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [25:0] jidx;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  dest;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } mem_wb_t;

  localparam if_id_t  IF_ID_NOP  = '{instr: NOP_INSTR, pc4: 32'h0};
  localparam id_ex_t  ID_EX_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;
  localparam mem_wb_t MEM_WB_NOP = '0;

  // Unrecognised encodings fall through with all control low, i.e. a NOP.
  function automatic ctrl_t decode_ctrl(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[31:26])
      OP_RTYPE: begin
        if (ins[5:0] == FN_ADDU || ins[5:0] == FN_SUBU) begin
          c.reg_write = 1'b1;
          c.use_rs    = 1'b1;
          c.use_rt    = 1'b1;
          c.alu_op    = (ins[5:0] == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end
      end
      OP_ORI: begin
        c.reg_write = 1'b1; c.alu_imm = 1'b1; c.use_rs = 1'b1; c.alu_op = ALU_OR;
      end
      OP_LUI: begin
        c.reg_write = 1'b1; c.alu_imm = 1'b1; c.alu_op = ALU_LUI;
      end
      OP_LW: begin
        c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_imm = 1'b1; c.use_rs = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1; c.alu_imm = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
      end
      OP_J:   c.jump = 1'b1;
      OP_JAL: begin
        c.jump = 1'b1; c.reg_write = 1'b1; c.alu_op = ALU_LINK;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipeline_cpu_gpr.sv
// 32x32 register file: two combinational reads with write-through, one write, $0 hardwired to zero.
module pipeline_cpu_gpr (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);

  logic [31:0] gp_registers [0:31];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) gp_registers[i] <= '0;
    end else if (we_i && wa_i != 5'd0) begin
      gp_registers[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'h0 :
                 (we_i && wa_i == ra1_i) ? wd_i : gp_registers[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'h0 :
                 (we_i && wa_i == ra2_i) ? wd_i : gp_registers[ra2_i];

endmodule

// File: rtl/pipeline_cpu_hazard_unit.sv
// Stall, flush and operand-bypass selection. FORWARDING_EN selects bypassing; otherwise RAW hazards stall.
module pipeline_cpu_hazard_unit
  import pipeline_cpu_pkg::*;
(
  input  logic     [4:0] id_rs_i,
  input  logic     [4:0] id_rt_i,
  input  logic           id_use_rs_i,
  input  logic           id_use_rt_i,
  input  logic           ex_reg_write_i,
  input  logic           ex_mem_read_i,
  input  logic     [4:0] ex_dest_i,
  input  logic     [4:0] ex_rs_i,
  input  logic     [4:0] ex_rt_i,
  input  logic           mem_reg_write_i,
  input  logic     [4:0] mem_dest_i,
  input  logic           wb_reg_write_i,
  input  logic     [4:0] wb_dest_i,
  input  logic           ex_redirect_i,
  output logic           stall_o,
  output logic           flush_o,
  output fwd_sel_e       fwd_a_o,
  output fwd_sel_e       fwd_b_o
);

  function automatic logic hits(input logic [4:0] src, input logic used,
                                input logic wr, input logic [4:0] dst);
    return used && wr && (dst != 5'd0) && (dst == src);
  endfunction

  assign flush_o = ex_redirect_i;

`ifdef FORWARDING_EN
  always_comb begin
    stall_o = ex_mem_read_i &&
              (hits(id_rs_i, id_use_rs_i, ex_reg_write_i, ex_dest_i) ||
               hits(id_rt_i, id_use_rt_i, ex_reg_write_i, ex_dest_i));
    fwd_a_o = FWD_NONE;
    fwd_b_o = FWD_NONE;
    // The younger producer (EX/MEM) must win over MEM/WB.
    if (hits(ex_rs_i, 1'b1, mem_reg_write_i, mem_dest_i))     fwd_a_o = FWD_MEM;
    else if (hits(ex_rs_i, 1'b1, wb_reg_write_i, wb_dest_i))  fwd_a_o = FWD_WB;
    if (hits(ex_rt_i, 1'b1, mem_reg_write_i, mem_dest_i))     fwd_b_o = FWD_MEM;
    else if (hits(ex_rt_i, 1'b1, wb_reg_write_i, wb_dest_i))  fwd_b_o = FWD_WB;
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{ex_mem_read_i, ex_rs_i, ex_rt_i, wb_reg_write_i, wb_dest_i};

  // Producers in WB are covered by register-file write-through, so only EX and MEM stall.
  always_comb begin
    stall_o = hits(id_rs_i, id_use_rs_i, ex_reg_write_i,  ex_dest_i)  ||
              hits(id_rt_i, id_use_rt_i, ex_reg_write_i,  ex_dest_i)  ||
              hits(id_rs_i, id_use_rs_i, mem_reg_write_i, mem_dest_i) ||
              hits(id_rt_i, id_use_rt_i, mem_reg_write_i, mem_dest_i);
    fwd_a_o = FWD_NONE;
    fwd_b_o = FWD_NONE;
  end
`endif

endmodule

// File: rtl/pipeline_cpu_im.sv
// Instruction memory: combinational read; the write port exists only so the array has a driver.
module pipeline_cpu_im #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] ins_memory [0:DEPTH-1];

  always_ff @(posedge clk_i) begin
    if (we_i) ins_memory[waddr_i] <= wdata_i;
  end

  assign rdata_o = ins_memory[raddr_i];

endmodule

// File: rtl/pipeline_cpu.sv
// Five-stage MIPS-subset pipeline (addu/subu/ori/lui/lw/sw/beq/j/jal), branches resolved in EX.
// Optional bypass network enabled by defining FORWARDING_EN.
module pipeline_cpu
  import pipeline_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          IM_DEPTH = 1024,
  parameter int          DM_DEPTH = 1024
) (
  input logic clock,
  input logic reset
);

  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DM_DEPTH);

  logic [31:0] pc, pc_d, pc_plus4;
  logic [31:0] instruction;
  logic        reg_write, EXE_reg_write, MEM_reg_write, WB_reg_write;

  if_id_t  if_id_q,  if_id_d;
  id_ex_t  id_ex_q,  id_ex_d, id_ex_dec;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic        stall, flush;
  fwd_sel_e    fwd_a, fwd_b;

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] link);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_OR:   return a | b;
      ALU_LUI:  return {b[15:0], 16'h0};
      ALU_LINK: return link;
      default:  return 32'h0;
    endcase
  endfunction

  // ---- IF ----
  assign pc_plus4 = pc + 32'd4;

  pipeline_cpu_im #(.DEPTH(IM_DEPTH)) IM (
    .clk_i   (clock),
    .we_i    (1'b0),
    .waddr_i ('0),
    .wdata_i ('0),
    .raddr_i (pc[IM_AW+1:2]),
    .rdata_o (instruction)
  );

  // ---- ID ----
  logic [31:0] id_ins, id_rs_val, id_rt_val, id_imm;
  logic [4:0]  id_dest;
  ctrl_t       id_ctrl;

  assign id_ins    = if_id_q.instr;
  assign id_ctrl   = decode_ctrl(id_ins);
  assign reg_write = id_ctrl.reg_write;

  pipeline_cpu_gpr GPR (
    .clk_i (clock),
    .rst_i (reset),
    .ra1_i (id_ins[25:21]),
    .ra2_i (id_ins[20:16]),
    .we_i  (mem_wb_q.reg_write),
    .wa_i  (mem_wb_q.dest),
    .wd_i  (mem_wb_q.wdata),
    .rd1_o (id_rs_val),
    .rd2_o (id_rt_val)
  );

  always_comb begin
    id_dest = id_ins[20:16];
    if (id_ctrl.jump)         id_dest = 5'd31;
    else if (!id_ctrl.alu_imm) id_dest = id_ins[15:11];
    id_imm = (id_ctrl.alu_op == ALU_OR) ? {16'h0, id_ins[15:0]}
                                        : {{16{id_ins[15]}}, id_ins[15:0]};
    id_ex_dec = '{ctrl: id_ctrl, pc4: if_id_q.pc4, rs: id_ins[25:21], rt: id_ins[20:16],
                  dest: id_dest, rs_val: id_rs_val, rt_val: id_rt_val, imm: id_imm,
                  jidx: id_ins[25:0]};
  end

  // ---- EX ----
  logic [31:0] ex_a, ex_b, ex_alu_b, ex_target;
  logic        ex_redirect;

  always_comb begin
    case (fwd_a)
      FWD_MEM: ex_a = ex_mem_q.alu_res;
      FWD_WB:  ex_a = mem_wb_q.wdata;
      default: ex_a = id_ex_q.rs_val;
    endcase
    case (fwd_b)
      FWD_MEM: ex_b = ex_mem_q.alu_res;
      FWD_WB:  ex_b = mem_wb_q.wdata;
      default: ex_b = id_ex_q.rt_val;
    endcase
    ex_alu_b    = id_ex_q.ctrl.alu_imm ? id_ex_q.imm : ex_b;
    ex_redirect = id_ex_q.ctrl.jump || (id_ex_q.ctrl.branch && (ex_a == ex_b));
    ex_target   = id_ex_q.ctrl.jump ? {id_ex_q.pc4[31:28], id_ex_q.jidx, 2'b00}
                                    : id_ex_q.pc4 + (id_ex_q.imm << 2);
    ex_mem_d = '{reg_write:  id_ex_q.ctrl.reg_write,
                 mem_read:   id_ex_q.ctrl.mem_read,
                 mem_write:  id_ex_q.ctrl.mem_write,
                 dest:       id_ex_q.dest,
                 alu_res:    alu(id_ex_q.ctrl.alu_op, ex_a, ex_alu_b, id_ex_q.pc4),
                 store_data: ex_b};
  end

  pipeline_cpu_hazard_unit HZD (
    .id_rs_i         (id_ins[25:21]),
    .id_rt_i         (id_ins[20:16]),
    .id_use_rs_i     (id_ctrl.use_rs),
    .id_use_rt_i     (id_ctrl.use_rt),
    .ex_reg_write_i  (id_ex_q.ctrl.reg_write),
    .ex_mem_read_i   (id_ex_q.ctrl.mem_read),
    .ex_dest_i       (id_ex_q.dest),
    .ex_rs_i         (id_ex_q.rs),
    .ex_rt_i         (id_ex_q.rt),
    .mem_reg_write_i (ex_mem_q.reg_write),
    .mem_dest_i      (ex_mem_q.dest),
    .wb_reg_write_i  (mem_wb_q.reg_write),
    .wb_dest_i       (mem_wb_q.dest),
    .ex_redirect_i   (ex_redirect),
    .stall_o         (stall),
    .flush_o         (flush),
    .fwd_a_o         (fwd_a),
    .fwd_b_o         (fwd_b)
  );

  // ---- MEM ----
  logic [31:0]      dm_q [0:DM_DEPTH-1];
  logic [DM_AW-1:0] dm_idx;

  assign dm_idx = ex_mem_q.alu_res[DM_AW+1:2];

  always_ff @(posedge clock) begin
    if (!reset && ex_mem_q.mem_write) dm_q[dm_idx] <= ex_mem_q.store_data;
  end

  assign mem_wb_d = '{reg_write: ex_mem_q.reg_write, dest: ex_mem_q.dest,
                      wdata: ex_mem_q.mem_read ? dm_q[dm_idx] : ex_mem_q.alu_res};

  // ---- WB / pipeline advance ----
  assign EXE_reg_write = id_ex_q.ctrl.reg_write;
  assign MEM_reg_write = ex_mem_q.reg_write;
  assign WB_reg_write  = mem_wb_q.reg_write;

  // A redirect from EX squashes the instruction that caused any stall, so flush wins.
  always_comb begin
    pc_d    = pc_plus4;
    if_id_d = '{instr: instruction, pc4: pc_plus4};
    id_ex_d = id_ex_dec;
    if (flush) begin
      pc_d    = ex_target;
      if_id_d = IF_ID_NOP;
      id_ex_d = ID_EX_NOP;
    end else if (stall) begin
      pc_d    = pc;
      if_id_d = if_id_q;
      id_ex_d = ID_EX_NOP;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      if_id_q  <= IF_ID_NOP;
      id_ex_q  <= ID_EX_NOP;
      ex_mem_q <= EX_MEM_NOP;
      mem_wb_q <= MEM_WB_NOP;
    end else begin
      pc       <= pc_d;
      if_id_q  <= if_id_d;
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed-program bench for pipeline_cpu: loads images into IM, runs, checks GPRs and pipeline nets.
module tb_pipeline_cpu;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  pipeline_cpu dut (
    .clock (clock),
    .reset (reset)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_im();
    for (int i = 0; i < 1024; i++) dut.IM.ins_memory[i] = 32'h0;
  endtask

  logic [31:0] prog_a [0:12];
  logic [31:0] prog_b [0:9];
  logic [31:0] prev_pc;
  logic [31:0] acc;
  int          holds;
`ifdef FORWARDING_EN
  localparam int HOLDS_A = 1;
`else
  localparam int HOLDS_A = 8;
`endif

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end

  initial begin
    prog_a = '{32'h34011234,   // ori  $1,$0,0x1234
               32'h34020010,   // ori  $2,$0,0x0010
               32'h00221821,   // addu $3,$1,$2
               32'h3C04FFFF,   // lui  $4,0xFFFF
               32'h3484FFFF,   // ori  $4,$4,0xFFFF
               32'h00842821,   // addu $5,$4,$4
               32'hAC010004,   // sw   $1,4($0)
               32'h8C060004,   // lw   $6,4($0)
               32'h00C63821,   // addu $7,$6,$6
               32'h10000002,   // beq  $0,$0,+2
               32'h34080088,   // ori  $8,$0,0x88 (squashed)
               32'h34090099,   // ori  $9,$0,0x99 (squashed)
               32'h340A00AA};  // ori  $10,$0,0xAA
    prog_b = '{32'h340A0001,   // 0x3000 ori $10,$0,1
               32'h0, 32'h0, 32'h0,
               32'h0C000C08,   // 0x3010 jal 0x3020
               32'h340B0011,   // 0x3014 ori $11 (flushed)
               32'h340C0022,   // 0x3018 ori $12 (flushed)
               32'h340D0033,   // 0x301C ori $13 (skipped)
               32'h34000005,   // 0x3020 ori $0,$0,5
               32'h340E0044};  // 0x3024 ori $14,$0,0x44

    clear_im();
    for (int i = 0; i < 13; i++) dut.IM.ins_memory[i] = prog_a[i];
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    check("rst_pc", dut.pc, 32'h3000);
    check("rst_id_rw", 32'(dut.reg_write), 32'h0);
    check("rst_ex_rw", 32'(dut.EXE_reg_write), 32'h0);

    holds = 0;
    for (int k = 1; k <= 40; k++) begin
      prev_pc = dut.pc;
      tick();
      if (dut.pc == prev_pc) holds++;
    end
    check("a_holds", 32'(holds), 32'(HOLDS_A));
    check("a_r1", dut.GPR.gp_registers[1], 32'h00001234);
    check("a_r2", dut.GPR.gp_registers[2], 32'h00000010);
    check("a_r3", dut.GPR.gp_registers[3], 32'h00001244);
    check("a_r4", dut.GPR.gp_registers[4], 32'hFFFFFFFF);
    check("a_r5", dut.GPR.gp_registers[5], 32'hFFFFFFFE);
    check("a_r6", dut.GPR.gp_registers[6], 32'h00001234);
    check("a_r7", dut.GPR.gp_registers[7], 32'h00002468);
    check("a_r8", dut.GPR.gp_registers[8], 32'h0);
    check("a_r9", dut.GPR.gp_registers[9], 32'h0);
    check("a_r10", dut.GPR.gp_registers[10], 32'h000000AA);

    reset = 1'b1;
    tick();
    check("rst2_pc", dut.pc, 32'h3000);
    check("rst2_id_rw", 32'(dut.reg_write), 32'h0);
    check("rst2_ex_rw", 32'(dut.EXE_reg_write), 32'h0);
    check("rst2_mem_rw", 32'(dut.MEM_reg_write), 32'h0);
    check("rst2_wb_rw", 32'(dut.WB_reg_write), 32'h0);
    acc = 32'h0;
    for (int i = 0; i < 32; i++) acc = acc | dut.GPR.gp_registers[i];
    check("rst2_gpr_or", acc, 32'h0);

    clear_im();
    for (int i = 0; i < 10; i++) dut.IM.ins_memory[i] = prog_b[i];
    reset = 1'b0;

    holds = 0;
    for (int k = 1; k <= 30; k++) begin
      prev_pc = dut.pc;
      tick();
      if (dut.pc == prev_pc) holds++;
      if (k == 5) check("b5_id_rw_jal", 32'(dut.reg_write), 32'h1);
      if (k == 6) check("b6_pc", dut.pc, 32'h3018);
      if (k == 7) begin
        check("b7_pc_target", dut.pc, 32'h3020);
        check("b7_id_rw", 32'(dut.reg_write), 32'h0);
        check("b7_ex_rw", 32'(dut.EXE_reg_write), 32'h0);
        check("b7_mem_rw", 32'(dut.MEM_reg_write), 32'h1);
      end
      if (k == 8) begin
        check("b8_ex_rw", 32'(dut.EXE_reg_write), 32'h0);
        check("b8_mem_rw", 32'(dut.MEM_reg_write), 32'h0);
        check("b8_wb_rw", 32'(dut.WB_reg_write), 32'h1);
      end
    end
    check("b_holds", 32'(holds), 32'h0);
    check("b_r31", dut.GPR.gp_registers[31], 32'h00003014);
    check("b_r10", dut.GPR.gp_registers[10], 32'h00000001);
    check("b_r11", dut.GPR.gp_registers[11], 32'h0);
    check("b_r12", dut.GPR.gp_registers[12], 32'h0);
    check("b_r13", dut.GPR.gp_registers[13], 32'h0);
    check("b_r14", dut.GPR.gp_registers[14], 32'h00000044);
    check("b_r0", dut.GPR.gp_registers[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
